// File: rtl/display_source_sequencer_if.sv
// Channel-data and selector/output bundle between the ADC processing stages
// and the display source sequencer.
interface display_source_sequencer_if #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned SEL_W    = $clog2(CHANNELS)
);
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
    logic                      next_pulse;
    logic                      auto_en;
    logic                      hold;
    logic [SEL_W-1:0]          sel_out;
    logic [WIDTH-1:0]          mux_out;
    logic [3:0]                decimal_point;
    logic                      out_valid;
    logic                      sel_changed;

    modport master (
        output in_data, in_valid, next_pulse, auto_en, hold,
        input  sel_out, mux_out, decimal_point, out_valid, sel_changed
    );

    modport slave (
        input  in_data, in_valid, next_pulse, auto_en, hold,
        output sel_out, mux_out, decimal_point, out_valid, sel_changed
    );
endinterface

// File: rtl/display_source_sequencer.sv
// Selects one of CHANNELS measurement streams for the 7-segment driver, with
// manual stepping, timed auto-scan, hold/freeze and per-channel valid capture.
module display_source_sequencer #(
    parameter int unsigned           WIDTH        = 16,
    parameter int unsigned           CHANNELS     = 4,
    parameter int unsigned           SEL_W        = $clog2(CHANNELS),
    parameter int unsigned           DWELL_CYCLES = 100_000_000,
    parameter logic [CHANNELS*4-1:0] DP_TABLE     = 16'h0020
) (
    input  logic                      clk,
    input  logic                      reset,
    display_source_sequencer_if.slave bus
);
    localparam int unsigned      CNT_W    = $clog2(DWELL_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(CHANNELS - 1);

    typedef enum logic {MANUAL, AUTO} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [SEL_W-1:0] r_sel;
    logic [SEL_W-1:0] w_sel_next;
    logic [WIDTH-1:0] r_mux;
    logic [3:0]       r_dp;
    logic             r_out_valid;
    logic             r_sel_changed;
    logic             w_advance;
    logic             w_capture;

    logic [WIDTH-1:0] w_ch [CHANNELS];
    logic [3:0]       w_dp [CHANNELS];

    always_comb begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            w_ch[i] = bus.in_data[i*WIDTH +: WIDTH];
            w_dp[i] = DP_TABLE[i*4 +: 4];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= MANUAL;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_advance    = 1'b0;
        case (r_state)
            MANUAL: begin
                w_advance  = bus.next_pulse && !bus.hold;
                w_cnt_next = '0;
                if (bus.auto_en) w_state_next = AUTO;
            end
            AUTO: begin
                // A manual pulse and dwell expiry coincide into one advance.
                w_advance = !bus.hold && (bus.next_pulse || r_cnt == CNT_LAST);
                if (bus.hold)       w_cnt_next = r_cnt;
                else if (w_advance) w_cnt_next = '0;
                else                w_cnt_next = r_cnt + 1'b1;
                if (!bus.auto_en) begin
                    w_state_next = MANUAL;
                    w_cnt_next   = '0;
                end
            end
            default: begin
                w_state_next = MANUAL;
                w_cnt_next   = '0;
            end
        endcase
        w_sel_next = (r_sel == SEL_LAST) ? '0 : r_sel + 1'b1;
        w_capture  = !w_advance && !bus.hold && bus.in_valid[r_sel];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sel         <= '0;
            r_mux         <= '0;
            r_dp          <= DP_TABLE[3:0];
            r_out_valid   <= 1'b0;
            r_sel_changed <= 1'b0;
        end else if (w_advance) begin
            r_sel         <= w_sel_next;
            r_mux         <= '0;
            r_dp          <= w_dp[w_sel_next];
            r_out_valid   <= 1'b0;
            r_sel_changed <= 1'b1;
        end else begin
            r_sel_changed <= 1'b0;
            if (w_capture) begin
                r_mux       <= w_ch[r_sel];
                r_out_valid <= 1'b1;
            end
        end
    end

    assign bus.sel_out       = r_sel;
    assign bus.mux_out       = r_mux;
    assign bus.decimal_point = r_dp;
    assign bus.out_valid     = r_out_valid;
    assign bus.sel_changed   = r_sel_changed;
endmodule

// File: tb/tb_display_source_sequencer.sv
// Self-checking bench: directed scenarios plus a randomized run against a
// behavioural model of the 4-channel, 8-cycle-dwell configuration.
module tb_display_source_sequencer;
    localparam int DWELL = 8;

    logic clk = 1'b0;
    logic rst4, rst3;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    display_source_sequencer_if #(.WIDTH(16), .CHANNELS(4)) b4 ();
    display_source_sequencer_if #(.WIDTH(16), .CHANNELS(3)) b3 ();

    display_source_sequencer #(
        .WIDTH(16), .CHANNELS(4), .DWELL_CYCLES(DWELL), .DP_TABLE(16'h0020)
    ) u4 (.clk(clk), .reset(rst4), .bus(b4));

    display_source_sequencer #(
        .WIDTH(16), .CHANNELS(3), .DWELL_CYCLES(DWELL), .DP_TABLE(12'h020)
    ) u3 (.clk(clk), .reset(rst3), .bus(b3));

    // Behavioural model of the 4-channel instance
    int          m_sel, m_el;
    bit          m_auto, m_ov, m_chg;
    logic [15:0] m_mux;

    task automatic model4();
        bit adv;
        if (rst4) begin
            m_sel = 0; m_el = 0; m_auto = 0; m_ov = 0; m_chg = 0; m_mux = '0;
            return;
        end
        adv = 0;
        if (!b4.hold)
            adv = b4.next_pulse || (m_auto && m_el == DWELL - 1);
        if (!m_auto || !b4.auto_en) m_el = 0;
        else if (!b4.hold)          m_el = adv ? 0 : m_el + 1;
        if (adv) begin
            m_sel = (m_sel + 1) % 4;
            m_mux = '0; m_ov = 0; m_chg = 1;
        end else begin
            m_chg = 0;
            if (!b4.hold && b4.in_valid[m_sel]) begin
                m_mux = b4.in_data[16*m_sel +: 16];
                m_ov  = 1;
            end
        end
        m_auto = b4.auto_en;
    endtask

    task automatic step();
        model4();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Steps until sel_changed on the 4-ch instance; n = -1 when the bound expires.
    task automatic wait_chg4(input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            step();
            if (b4.sel_changed) begin n = i; return; end
        end
    endtask

    task automatic wait_chg3(input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            step();
            if (b3.sel_changed) begin n = i; return; end
        end
    endtask

    task automatic test_reset();
        rst4 = 1; rst3 = 1;
        steps(2);
        rst4 = 0; rst3 = 0;
        n_tests++;
        if (b4.sel_out !== 2'd0 || b4.mux_out !== 16'h0 || b4.decimal_point !== 4'b0000 ||
            b4.out_valid !== 1'b0 || b4.sel_changed !== 1'b0) begin
            n_fail++;
            $display("FAIL reset4: sel=%0d mux=%h dp=%b ov=%b chg=%b, want 0/0000/0000/0/0",
                     b4.sel_out, b4.mux_out, b4.decimal_point, b4.out_valid, b4.sel_changed);
        end
        n_tests++;
        if (b3.sel_out !== 2'd0 || b3.mux_out !== 16'h0 || b3.out_valid !== 1'b0 ||
            b3.sel_changed !== 1'b0) begin
            n_fail++;
            $display("FAIL reset3: sel=%0d mux=%h ov=%b chg=%b, want 0/0000/0/0",
                     b3.sel_out, b3.mux_out, b3.out_valid, b3.sel_changed);
        end
    endtask

    task automatic test_manual_wrap();
        for (int k = 1; k <= 4; k++) begin
            b4.next_pulse = 1;
            step();
            b4.next_pulse = 0;
            n_tests++;
            if (b4.sel_out !== 2'(k % 4) || b4.sel_changed !== 1'b1 ||
                b4.decimal_point !== ((k % 4 == 1) ? 4'b0010 : 4'b0000)) begin
                n_fail++;
                $display("FAIL wrap_step%0d: sel=%0d chg=%b dp=%b, want sel=%0d chg=1",
                         k, b4.sel_out, b4.sel_changed, b4.decimal_point, k % 4);
            end
            step();
            n_tests++;
            if (b4.sel_changed !== 1'b0) begin
                n_fail++;
                $display("FAIL wrap_chg_drop%0d: chg=%b want 0", k, b4.sel_changed);
            end
            step();
        end
    endtask

    task automatic test_capture();
        b4.next_pulse = 1; step(); step(); b4.next_pulse = 0;
        n_tests++;
        if (b4.sel_out !== 2'd2 || b4.mux_out !== 16'h0 || b4.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL cap_setup: sel=%0d mux=%h ov=%b want 2/0000/0",
                     b4.sel_out, b4.mux_out, b4.out_valid);
        end
        b4.in_data  = {16'h1111, 16'h0ABC, 16'h2222, 16'h3333};
        b4.in_valid = 4'b0100;
        step();
        b4.in_valid = 4'b0000;
        n_tests++;
        if (b4.mux_out !== 16'h0ABC || b4.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL cap_latency: mux=%h ov=%b want 0abc/1", b4.mux_out, b4.out_valid);
        end
        b4.in_data  = {16'h4444, 16'hFFFF, 16'h5555, 16'h1234};
        b4.in_valid = 4'b0001;
        step();
        n_tests++;
        if (b4.mux_out !== 16'h0ABC || b4.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL cap_ignore_other: mux=%h ov=%b want 0abc/1", b4.mux_out, b4.out_valid);
        end
        b4.in_valid   = 4'b0100;
        b4.next_pulse = 1;
        step();
        b4.in_valid   = 4'b0000;
        b4.next_pulse = 0;
        n_tests++;
        if (b4.sel_out !== 2'd3 || b4.mux_out !== 16'h0 || b4.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL cap_adv_priority: sel=%0d mux=%h ov=%b want 3/0000/0",
                     b4.sel_out, b4.mux_out, b4.out_valid);
        end
        b4.in_valid = 4'b1000;
        step();
        b4.in_valid = 4'b0000;
        n_tests++;
        if (b4.mux_out !== 16'h4444 || b4.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL cap_new_channel: mux=%h ov=%b want 4444/1", b4.mux_out, b4.out_valid);
        end
    endtask

    task automatic test_auto_scan();
        int n;
        rst4 = 1; step(); rst4 = 0;
        b4.auto_en = 1;
        step();
        for (int k = 1; k <= 4; k++) begin
            wait_chg4(3 * DWELL, n);
            n_tests++;
            if (n !== DWELL || b4.sel_out !== 2'(k % 4)) begin
                n_fail++;
                $display("FAIL auto_period%0d: cycles=%0d sel=%0d want %0d/%0d",
                         k, n, b4.sel_out, DWELL, k % 4);
            end
        end
        steps(5);
        b4.next_pulse = 1;
        step();
        b4.next_pulse = 0;
        n_tests++;
        if (b4.sel_changed !== 1'b1 || b4.sel_out !== 2'd1) begin
            n_fail++;
            $display("FAIL auto_pulse_adv: chg=%b sel=%0d want 1/1", b4.sel_changed, b4.sel_out);
        end
        wait_chg4(3 * DWELL, n);
        n_tests++;
        if (n !== DWELL || b4.sel_out !== 2'd2) begin
            n_fail++;
            $display("FAIL auto_pulse_restart: cycles=%0d sel=%0d want %0d/2", n, b4.sel_out, DWELL);
        end
    endtask

    task automatic test_hold();
        int          n, bad;
        int          h_sel;
        logic [15:0] h_mux;
        bit          h_ov;
        steps(3);
        h_sel = m_sel; h_mux = m_mux; h_ov = m_ov;
        b4.hold     = 1;
        b4.in_data  = {4{16'hBEEF}};
        b4.in_valid = 4'b1111;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            b4.next_pulse = (i == 10);
            step();
            if (b4.sel_changed !== 1'b0 || b4.sel_out !== 2'(h_sel) || b4.mux_out !== h_mux ||
                b4.out_valid !== h_ov || b4.decimal_point !== ((h_sel == 1) ? 4'b0010 : 4'b0000))
                bad++;
        end
        b4.next_pulse = 0;
        b4.in_valid   = 4'b0000;
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL hold_frozen: %0d of 20 held cycles changed, want 0", bad);
        end
        b4.hold = 0;
        wait_chg4(3 * DWELL, n);
        n_tests++;
        if (n !== 5 || b4.sel_out !== 2'((h_sel + 1) % 4)) begin
            n_fail++;
            $display("FAIL hold_resume: cycles=%0d sel=%0d want 5/%0d", n, b4.sel_out, (h_sel + 1) % 4);
        end
        b4.auto_en = 0;
        step();
    endtask

    task automatic test_odd_channels();
        int n, bad;
        for (int k = 1; k <= 3; k++) begin
            b3.next_pulse = 1; step(); b3.next_pulse = 0;
            n_tests++;
            if (b3.sel_out !== 2'(k % 3) || b3.sel_changed !== 1'b1) begin
                n_fail++;
                $display("FAIL odd_step%0d: sel=%0d chg=%b want %0d/1", k, b3.sel_out, b3.sel_changed, k % 3);
            end
            step();
        end
        b3.auto_en = 1;
        step();
        wait_chg3(3 * DWELL, n);
        n_tests++;
        if (n !== DWELL || b3.sel_out !== 2'd1) begin
            n_fail++;
            $display("FAIL odd_auto: cycles=%0d sel=%0d want %0d/1", n, b3.sel_out, DWELL);
        end
        steps(6);
        b3.in_valid = 3'b010;
        b3.in_data  = {16'h0, 16'h7777, 16'h0};
        rst3 = 1; b3.auto_en = 0;
        step();
        rst3 = 0; b3.in_valid = 3'b000;
        n_tests++;
        if (b3.sel_out !== 2'd0 || b3.mux_out !== 16'h0 || b3.out_valid !== 1'b0 ||
            b3.sel_changed !== 1'b0 || b3.decimal_point !== 4'b0000) begin
            n_fail++;
            $display("FAIL odd_reset_mid_scan: sel=%0d mux=%h ov=%b chg=%b dp=%b want all 0",
                     b3.sel_out, b3.mux_out, b3.out_valid, b3.sel_changed, b3.decimal_point);
        end
        bad = 0;
        for (int i = 0; i < 3 * DWELL; i++) begin
            step();
            if (b3.sel_changed !== 1'b0 || b3.sel_out !== 2'd0) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL odd_manual_after_reset: %0d cycles advanced, want 0", bad);
        end
        b3.auto_en = 1;
        step();
        wait_chg3(3 * DWELL, n);
        n_tests++;
        if (n !== DWELL || b3.sel_out !== 2'd1) begin
            n_fail++;
            $display("FAIL odd_auto_restart: cycles=%0d sel=%0d want %0d/1", n, b3.sel_out, DWELL);
        end
        b3.auto_en = 0;
    endtask

    task automatic test_random();
        int bad_sel = 0, bad_mux = 0, bad_flags = 0;
        rst4 = 1; step(); rst4 = 0;
        for (int i = 0; i < 1500; i++) begin
            b4.next_pulse = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 39) == 0) b4.auto_en = ~b4.auto_en;
            if ($urandom_range(0, 11) == 0) b4.hold = ~b4.hold;
            b4.in_valid = 4'($urandom);
            b4.in_data  = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
            if ($urandom_range(0, 499) == 0) rst4 = 1;
            step();
            rst4 = 0;
            if (b4.sel_out !== 2'(m_sel)) bad_sel++;
            if (b4.mux_out !== m_mux) bad_mux++;
            if (b4.out_valid !== m_ov || b4.sel_changed !== m_chg ||
                b4.decimal_point !== ((m_sel == 1) ? 4'b0010 : 4'b0000)) bad_flags++;
        end
        n_tests++;
        if (bad_sel != 0) begin
            n_fail++;
            $display("FAIL rand_sel: %0d cycles disagree with model, want 0", bad_sel);
        end
        n_tests++;
        if (bad_mux != 0) begin
            n_fail++;
            $display("FAIL rand_mux: %0d cycles disagree with model, want 0", bad_mux);
        end
        n_tests++;
        if (bad_flags != 0) begin
            n_fail++;
            $display("FAIL rand_flags: %0d cycles disagree with model, want 0", bad_flags);
        end
        b4.hold = 0; b4.auto_en = 0; b4.next_pulse = 0; b4.in_valid = '0;
    endtask

    initial begin
        rst4 = 1; rst3 = 1;
        b4.in_data = '0; b4.in_valid = '0; b4.next_pulse = 0; b4.auto_en = 0; b4.hold = 0;
        b3.in_data = '0; b3.in_valid = '0; b3.next_pulse = 0; b3.auto_en = 0; b3.hold = 0;
        test_reset();
        test_manual_wrap();
        test_capture();
        test_auto_scan();
        test_hold();
        test_odd_channels();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/display_source_sequencer.md
# display_source_sequencer

Parametrised display-source selector for the voltmeter datapath. It picks one of CHANNELS measurement streams (averaged ADC, scaled voltage, raw ADC, ...) for the 7-segment driver and registers the chosen value with its decimal-point pattern. Channel selection is either manual (step pulses) or automatic (timed scan). The block also supports freeze (hold) and per-channel valid tracking. It sits between the ADC processing stages and the seven-segment display controller.

## Interface
- WIDTH, 16, bits per channel value
- CHANNELS, 4, number of input channels (2..16, need not be power of 2)
- SEL_W, $clog2(CHANNELS), selector width
- DWELL_CYCLES, 100_000_000, clk cycles per channel in auto-scan (>= 2)
- DP_TABLE, 16'h0020, packed CHANNELS*4 decimal-point patterns; channel i at bits [4i+3:4i]; 1 = DP on
- clk  input  1  system clock, all logic rising-edge
- reset  input  1  synchronous, active-high
- in_data  input  CHANNELS*WIDTH  channel i at bits [i*WIDTH +: WIDTH]
- in_valid  input  CHANNELS  per-channel sample strobe, one cycle per new sample
- next_pulse  input  1  single-cycle request to advance to next channel
- auto_en  input  1  level; 1 = auto-scan mode, 0 = manual
- hold  input  1  level; freezes selection, dwell counter and outputs
- sel_out  output  SEL_W  currently selected channel
- mux_out  output  WIDTH  registered value of selected channel
- decimal_point  output  4  DP_TABLE entry for sel_out
- out_valid  output  1  mux_out holds a sample of the current sel_out
- sel_changed  output  1  one-cycle pulse after every selection change

## Operation
- One clock domain; synchronous, active-high reset.
- FSM states: MANUAL, AUTO.
  - MANUAL -> AUTO when auto_en=1.
  - AUTO -> MANUAL when auto_en=0.
  - sel_out is retained across every transition.
  - Entering AUTO clears the dwell counter.
- Advance event: sel_out <= (sel_out == CHANNELS-1) ? 0 : sel_out+1.
- Advance source, MANUAL: next_pulse=1 and hold=0.
- Advance source, AUTO: dwell counter reaches DWELL_CYCLES-1 and hold=0; the counter then returns to 0.
- next_pulse in AUTO also advances and restarts the dwell counter. Simultaneous pulse and dwell expiry give a single advance.
- On an advance, the next edge applies all of the following:
  - sel_out = new channel
  - decimal_point = DP_TABLE[new]
  - mux_out = 0
  - out_valid = 0
  - sel_changed = 1
- Capture: if no advance occurs this cycle, hold=0 and in_valid[sel_out]=1, then mux_out <= in_data slice of sel_out and out_valid <= 1.
- Advance has priority over capture in the same cycle; that sample is dropped.
- in_valid on non-selected channels is ignored.
- mux_out holds its last value between strobes.
- hold=1 has these effects:
  - next_pulse is dropped (not queued).
  - The dwell counter pauses.
  - sel_out, mux_out, decimal_point and out_valid are frozen.
  - sel_changed is 0.
  - Releasing hold resumes the count from the paused value.
- hold and next_pulse together: hold wins.
- Reset values: state = MANUAL, sel_out = 0, mux_out = 0, decimal_point = DP_TABLE[0], out_valid = 0, sel_changed = 0, dwell counter = 0.
- Reset mid-scan or mid-hold discards all state.

## Timing
- Capture latency: in_valid at cycle t gives mux_out and out_valid at t+1.
- Advance latency: next_pulse at t gives new sel_out, decimal_point and sel_changed at t+1. sel_changed drops at t+2 unless another advance occurs.
- Earliest capture on a new channel: an in_valid at t+1 updates mux_out at t+2.
- Auto-scan period: exactly DWELL_CYCLES cycles between sel_changed pulses while hold=0.
- Dwell counter width: $clog2(DWELL_CYCLES).
- The counter never exceeds DWELL_CYCLES-1.
- All outputs are registered; there is no combinational path from input to output.

## Test plan
- Reset check, defaults: assert reset for 2 cycles. Required: sel_out=0, mux_out=0, decimal_point=4'b0000, out_valid=0, sel_changed=0.
- Manual wrap: CHANNELS=4, hold=0, 4 spaced next_pulse. Required: sel_out goes 1,2,3,0, each with a 1-cycle sel_changed. decimal_point=4'b0010 only while sel_out=1.
- Capture and latency: sel_out=2, in_data ch2=16'h0ABC with in_valid[2] at t. Required: mux_out=16'h0ABC and out_valid=1 at t+1. in_valid[0] alone leaves mux_out unchanged.
- Auto-scan with DWELL_CYCLES=8: set auto_en=1. Required: sel_changed every 8 cycles, sel_out 0,1,2,3,0.
  - Inject next_pulse at count 5: immediate advance, and the next auto-advance follows 8 cycles later.
- Hold: in AUTO, assert hold for 20 cycles at count 3, with next_pulse pulsed during hold. Required: no sel_changed, outputs frozen, pulse dropped. After release, the advance occurs 5 cycles later.
- Odd channel count and reset mid-scan: CHANNELS=3 stepping gives 0,1,2,0. Then reset in AUTO at count 6. Required: all reset values and MANUAL state; no advance until auto_en is re-asserted.
